// File: rtl/coproc_bridge_pkg.sv
// rtl/coproc_bridge_pkg.sv - shared constants and types for the coprocessor bridge
package coproc_bridge_pkg;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_START = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;

  localparam logic [1:0] RSEL_STATUS = 2'd0;
  localparam logic [1:0] RSEL_HEAD   = 2'd1;
  localparam logic [1:0] RSEL_INCNT  = 2'd2;
  localparam logic [1:0] RSEL_PARAM  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_TO_ERR    = 2;
  localparam int STAT_OVF_ERR   = 3;
  localparam int STAT_START_ERR = 4;
  localparam int STAT_RES_EMPTY = 5;
  localparam int STAT_RES_FULL  = 6;
  localparam int STAT_CNT_LSB   = 8;

endpackage

// File: rtl/coproc_bridge_fifo.sv
// rtl/coproc_bridge_fifo.sv - small synchronous FIFO used for job and result words
module bridge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are meaningless while the count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; clear wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/coproc_bridge.sv
// rtl/coproc_bridge.sv - PIO host to streaming coprocessor job bridge
module coproc_bridge
  import coproc_bridge_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NWORDS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              host_stb,
  input  logic [2:0]        host_op,
  input  logic [31:0]       host_wdata,
  input  logic [1:0]        host_rsel,
  output logic [31:0]       host_rdata,
  input  logic              cp_ready,
  output logic              cp_in_valid,
  output logic [DATA_W-1:0] cp_in_data,
  input  logic              cp_out_valid,
  input  logic [DATA_W-1:0] cp_out_data
);

  localparam int CNT_W = $clog2(NWORDS) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [7:0] DW8 = 8'(DATA_W);
  localparam logic [7:0] NW8 = 8'(NWORDS);

  state_t state, next_state;

  logic              stb_q;
  logic              stb_edge;
  logic              cmd_clear, cmd_load, cmd_start, cmd_pop;
  logic              in_push, in_pop, res_push, res_clr;
  logic              set_ovf, set_start_err, set_to;
  logic              ovf_err, start_err, to_err;
  logic [CNT_W-1:0]  rx_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] in_head, res_head;
  logic [CNT_W-1:0]  in_count, res_count;
  logic              in_full, in_empty, res_full, res_empty;
  logic [31:0]       status;
  logic              unused_wdata;

  assign unused_wdata = ^host_wdata;

  assign stb_edge  = host_stb & ~stb_q;
  assign cmd_clear = stb_edge & (host_op == OP_CLEAR);
  assign cmd_load  = stb_edge & (host_op == OP_LOAD);
  assign cmd_start = stb_edge & (host_op == OP_START);
  assign cmd_pop   = stb_edge & (host_op == OP_POP);

  bridge_fifo #(.WIDTH(DATA_W), .DEPTH(NWORDS)) u_in_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_push),
    .pop   (in_pop),
    .clear (cmd_clear),
    .din   (host_wdata[DATA_W-1:0]),
    .head  (in_head),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  bridge_fifo #(.WIDTH(DATA_W), .DEPTH(NWORDS)) u_res_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (res_push),
    .pop   (cmd_pop),
    .clear (res_clr),
    .din   (cp_out_data),
    .head  (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  // Strobe history so a held strobe only fires one command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stb_q <= 1'b0;
    else       stb_q <= host_stb;
  end

  // Job state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus the buffer strobes and error-set pulses it implies.
  always_comb begin
    next_state    = state;
    in_push       = 1'b0;
    in_pop        = 1'b0;
    res_push      = 1'b0;
    res_clr       = 1'b0;
    cp_in_valid   = 1'b0;
    set_ovf       = 1'b0;
    set_start_err = 1'b0;
    set_to        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (cmd_load) begin
          if (in_full) set_ovf = 1'b1;
          else         in_push = 1'b1;
        end
        if (cmd_start) begin
          if (in_count == CNT_W'(NWORDS)) begin
            res_clr    = 1'b1;
            next_state = ST_FEED;
          end else begin
            set_start_err = 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (cp_ready && !in_empty) begin
          cp_in_valid = 1'b1;
          in_pop      = 1'b1;
          if (in_count == CNT_W'(1)) next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        res_push = cp_out_valid;
        if (cp_out_valid && rx_cnt == CNT_W'(NWORDS - 1)) begin
          next_state = ST_DONE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          set_to     = 1'b1;
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (cmd_clear) begin
      next_state = ST_IDLE;
      in_push    = 1'b0;
      res_push   = 1'b0;
      res_clr    = 1'b1;
      set_ovf    = 1'b0;
      set_to     = 1'b0;
    end
  end

  assign cp_in_data = (state == ST_FEED) ? in_head : '0;

  // Result and timeout counters; both restart from zero on each entry to WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_cnt  <= '0;
      tmo_cnt <= '0;
    end else if (cmd_clear || state != ST_WAIT || next_state != ST_WAIT) begin
      rx_cnt  <= '0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (res_push) rx_cnt <= rx_cnt + CNT_W'(1);
    end
  end

  // Sticky error flags, only cleared by CLEAR or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err   <= 1'b0;
      start_err <= 1'b0;
      to_err    <= 1'b0;
    end else if (cmd_clear) begin
      ovf_err   <= 1'b0;
      start_err <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      if (set_ovf)       ovf_err   <= 1'b1;
      if (set_start_err) start_err <= 1'b1;
      if (set_to)        to_err    <= 1'b1;
    end
  end

  // Status word assembly.
  always_comb begin
    status                                = '0;
    status[STAT_BUSY]                     = (state == ST_FEED) || (state == ST_WAIT);
    status[STAT_DONE]                     = (state == ST_DONE);
    status[STAT_TO_ERR]                   = to_err;
    status[STAT_OVF_ERR]                  = ovf_err;
    status[STAT_START_ERR]                = start_err;
    status[STAT_RES_EMPTY]                = res_empty;
    status[STAT_RES_FULL]                 = res_full;
    status[STAT_CNT_LSB+7:STAT_CNT_LSB]   = 8'(res_count);
  end

  // Registered host read mux.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      host_rdata <= '0;
    end else begin
      case (host_rsel)
        RSEL_STATUS: host_rdata <= status;
        RSEL_HEAD:   host_rdata <= 32'(res_head);
        RSEL_INCNT:  host_rdata <= 32'(in_count);
        default:     host_rdata <= {DW8, NW8, 16'h0000};
      endcase
    end
  end

endmodule

// File: doc/coproc_bridge.md
COPROC_BRIDGE -- requirements
Module: coproc_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, coprocessor word width (1..32).
REQ-002 SHALL have parameter NWORDS, default 4, words per job and per result (2..64, power of 2).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles before abort (>=2).
REQ-004 SHALL have ports: one clock; reset is asynchronous and active-low, named as below.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 host_stb  in  1  level strobe from processor PIO; command executes on its rising edge only.
REQ-008 host_op  in  3  opcode sampled at strobe edge: 0 CLEAR, 1 LOAD, 2 START, 3 POP, 4-7 ignored.
REQ-009 host_wdata  in  32  LOAD data; low DATA_W bits used.
REQ-010 host_rsel  in  2  read select: 0 status, 1 result head, 2 input count, 3 parameter word.
REQ-011 host_rdata  out  32  registered read mux output.
REQ-012 cp_ready  in  1  coprocessor can accept a word this cycle.
REQ-013 cp_in_valid / cp_in_data  out  1 / DATA_W  word to coprocessor.
REQ-014 cp_out_valid / cp_out_data  in  1 / DATA_W  result word from coprocessor.

Function
REQ-015 Strobe edge = host_stb high now and low the previous cycle; at most one command per edge; a held strobe executes once.
REQ-016 FSM states IDLE, FEED, WAIT, DONE; reset state IDLE.
REQ-017 LOAD in IDLE/DONE pushes word into input buffer (depth NWORDS); buffer full -> word dropped, sticky ovf_err set; LOAD in FEED/WAIT ignored.
REQ-018 START in IDLE/DONE with input count == NWORDS -> clear result buffer, FEED next cycle; count != NWORDS -> ignored, sticky start_err set.
REQ-019 FEED: each cycle cp_ready=1, drive cp_in_valid=1 with next buffered word, oldest first; cp_ready=0 -> cp_in_valid=0, no advance; after word NWORDS -> WAIT, input count 0.
REQ-020 WAIT: each cp_out_valid pushes cp_out_data into result buffer (depth NWORDS); after NWORDS results -> DONE.
REQ-021 WAIT timeout counter starts at 0 on entry, +1 per cycle; reaching TIMEOUT-1 without completion -> sticky to_err set, DONE with partial results kept.
REQ-022 cp_out_valid outside WAIT ignored; cp_out_valid in FEED SHALL NOT be captured.
REQ-023 POP removes result head; empty -> no effect, no error; POP legal in any state.
REQ-024 CLEAR in any state -> IDLE next cycle, both buffers emptied, counters and error flags zeroed, cp_in_valid low from next cycle.
REQ-025 Status word: [0] busy (FEED/WAIT), [1] done (DONE), [2] to_err, [3] ovf_err, [4] start_err, [5] result empty, [6] result full, [15:8] result count, others 0.
REQ-026 rsel 1 returns result head zero-extended (0 when empty); rsel 2 returns input count; rsel 3 returns {DATA_W[7:0], NWORDS[7:0], 16'h0}.
REQ-027 host_rdata updates one cycle after host_rsel or underlying state changes.

Reset
REQ-028 rstn low -> immediately: state IDLE, cp_in_valid 0, cp_in_data 0, host_rdata 0, buffers empty, all counters and errors 0, strobe history 0.
REQ-029 Reset mid-job SHALL abort with no further cp_in_valid pulses after rstn release until a new START.

Structure
REQ-030 Package coproc_bridge_pkg SHALL hold opcode constants, rsel constants, state encoding and status bit indices.
REQ-031 One sub-module bridge_fifo (parameters width, depth; push, pop, clear, head, count, full, empty) SHALL be instantiated twice: input and result buffers.

Verification (DATA_W=16, NWORDS=4, TIMEOUT=16)
REQ-032 LOAD 0x11,0x22,0x33,0x44, START, cp_ready=1 -> cp_in_valid 4 consecutive cycles with 0x11..0x44; return 4 results -> status done=1, result count 4, POPs read in order.
REQ-033 LOAD 5 words -> fifth dropped, ovf_err=1, input count 4; START with 3 words -> start_err=1, state stays IDLE.
REQ-034 cp_ready toggling 1,0,1,0 during FEED -> no word skipped or repeated, cp_in_valid only when cp_ready=1.
REQ-035 Return 2 results then silence -> to_err=1 and done=1 after 16 WAIT cycles, result count 2.
REQ-036 host_stb held high 10 cycles with op LOAD -> exactly one word loaded; CLEAR during WAIT -> IDLE, status 0x20 next read.
REQ-037 rstn pulsed low during FEED -> all outputs 0 asynchronously, no cp_in_valid after release.
